id_operand_stage: RTL

- Parametrised decode-stage operand unit for the pipelined RV32I core: holds the IF->ID pipeline register with its valid/allow-in handshake.
- Resolves rs1/rs2 across a configurable number of forwarding sources (EX, MEM, WB, ...), ordered by priority.
- Stalls on any matching producer whose result is not yet available, generalising the single EX load-use case.
- Supports branch flush and exposes a saturating stall-cycle performance counter. Decoder, RF and SEXT stay outside; this block feeds them.

---
 rtl/id_operand_stage_if.sv | 24 ++
 rtl/id_operand_stage.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/id_operand_stage_if.sv
// IF->ID->EX pipeline handshake bundle for the decode operand stage.
// master = surrounding pipeline (IF producer / EX consumer), slave = the ID stage.
interface id_operand_stage_if #(
  parameter int PAYLOAD_W = 64
);
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_inst;
  logic [PAYLOAD_W-1:0] in_payload;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          id_inst;
  logic [PAYLOAD_W-1:0] id_payload;

  modport master (
    output in_valid, in_inst, in_payload, out_ready,
    input  in_ready, out_valid, id_inst, id_payload
  );

  modport slave (
    input  in_valid, in_inst, in_payload, out_ready,
    output in_ready, out_valid, id_inst, id_payload
  );
endinterface

// File: rtl/id_operand_stage.sv
// Decode-stage operand unit: IF->ID register, priority forwarding across
// NUM_FWD producers, pending-result stall and a saturating stall counter.

module id_fwd_resolve #(
  parameter int XLEN    = 32,
  parameter int NUM_FWD = 3
) (
  input  logic [4:0]              rs,
  input  logic                    rs_en,
  input  logic                    id_valid,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD-1:0]      fwd_we,
  input  logic [5*NUM_FWD-1:0]    fwd_rd,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]      fwd_data_ok,
  input  logic [XLEN-1:0]         rf_rd,
  output logic [XLEN-1:0]         op,
  output logic                    hazard
);
  logic found;
  logic pend;

  // Scan youngest-first; the first match owns the operand even if its data is pending.
  always_comb begin
    op    = rf_rd;
    pend  = 1'b0;
    found = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!found && fwd_valid[i] && fwd_we[i] &&
          fwd_rd[5*i +: 5] != 5'd0 && fwd_rd[5*i +: 5] == rs) begin
        found = 1'b1;
        op    = fwd_data[XLEN*i +: XLEN];
        pend  = !fwd_data_ok[i];
      end
    end
    if (rs == 5'd0) begin
      op   = '0;
      pend = 1'b0;
    end
  end

  assign hazard = pend && id_valid && rs_en;
endmodule

module id_operand_stage #(
  parameter int XLEN      = 32,
  parameter int PAYLOAD_W = 64,
  parameter int NUM_FWD   = 3,
  parameter int CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  id_operand_stage_if.slave       bus,
  input  logic                    flush,
  input  logic                    rs1_en,
  input  logic                    rs2_en,
  output logic [4:0]              rs1_addr,
  output logic [4:0]              rs2_addr,
  input  logic [XLEN-1:0]         rf_rd1,
  input  logic [XLEN-1:0]         rf_rd2,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD-1:0]      fwd_we,
  input  logic [5*NUM_FWD-1:0]    fwd_rd,
  input  logic [XLEN*NUM_FWD-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]      fwd_data_ok,
  output logic [XLEN-1:0]         op1,
  output logic [XLEN-1:0]         op2,
  output logic                    stall,
  output logic [CNT_W-1:0]        stall_cnt,
  input  logic                    stall_cnt_clr
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic                 id_valid;
  logic [31:0]          id_inst;
  logic [PAYLOAD_W-1:0] id_payload;
  logic                 ready_go;
  logic                 in_ready;
  logic                 accept;

  logic [1:0][4:0]      rs_addr;
  logic [1:0]           rs_en;
  logic [1:0][XLEN-1:0] rf_rd;
  logic [1:0][XLEN-1:0] op;
  logic [1:0]           hazard;

  assign rs1_addr   = id_inst[19:15];
  assign rs2_addr   = id_inst[24:20];
  assign rs_addr    = {rs2_addr, rs1_addr};
  assign rs_en      = {rs2_en, rs1_en};
  assign rf_rd      = {rf_rd2, rf_rd1};

  genvar p;
  generate
    for (p = 0; p < 2; p++) begin : g_port
      id_fwd_resolve #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_res (
        .rs          (rs_addr[p]),
        .rs_en       (rs_en[p]),
        .id_valid    (id_valid),
        .fwd_valid   (fwd_valid),
        .fwd_we      (fwd_we),
        .fwd_rd      (fwd_rd),
        .fwd_data    (fwd_data),
        .fwd_data_ok (fwd_data_ok),
        .rf_rd       (rf_rd[p]),
        .op          (op[p]),
        .hazard      (hazard[p])
      );
    end
  endgenerate

  assign op1        = op[0];
  assign op2        = op[1];
  assign ready_go   = !(|hazard);
  assign stall      = id_valid && !ready_go;
  assign in_ready   = !id_valid || (ready_go && bus.out_ready);
  // A flush cancels anything arriving in the same cycle.
  assign accept     = bus.in_valid && in_ready && !flush;

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = id_valid && ready_go;
  assign bus.id_inst    = id_inst;
  assign bus.id_payload = id_payload;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_valid   <= 1'b0;
      id_inst    <= NOP;
      id_payload <= '0;
      stall_cnt  <= '0;
    end else begin
      if (flush)         id_valid <= 1'b0;
      else if (in_ready) id_valid <= bus.in_valid;

      if (accept) begin
        id_inst    <= bus.in_inst;
        id_payload <= bus.in_payload;
      end

      if (stall_cnt_clr)
        stall_cnt <= '0;
      else if (stall && !flush && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule
